// File: rtl/nn_pkg.sv
// Shared constants and types for the argmax classifier stage.
// Widths are derived from the class and sample counts.
package nn_pkg;

    localparam int DATA_W    = 8;
    localparam int N_CLASSES = 10;
    localparam int N_SAMPLES = 3136;
    localparam int CLS_W     = $clog2(N_CLASSES);
    localparam int CNT_W     = $clog2(N_SAMPLES);

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        FINISH = 1'b1
    } state_e;

endpackage

// File: rtl/nn_argmax_classifier_if.sv
// Score stream in, argmax result and status out.
// master drives scores, slave is the classifier.
interface nn_argmax_classifier_if;
    import nn_pkg::*;

    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              out_valid;
    logic [CLS_W-1:0]  out_class;
    logic [DATA_W-1:0] out_score;
    logic [CNT_W-1:0]  sample_idx;
    logic              done;
    logic              err;

    modport master (
        output in_valid, in_data, in_last,
        input  out_valid, out_class, out_score,
        input  sample_idx, done, err
    );

    modport slave (
        input  in_valid, in_data, in_last,
        output out_valid, out_class, out_score,
        output sample_idx, done, err
    );

endinterface

// File: rtl/nn_argmax_classifier.sv
// Per-sample argmax over a signed score stream.
// Result is registered one cycle after the last beat.
module nn_argmax_classifier
    import nn_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    nn_argmax_classifier_if.slave bus
);

    localparam logic [CLS_W-1:0] CLS_LAST = CLS_W'(N_CLASSES - 1);
    localparam logic [CNT_W-1:0] SMP_LAST = CNT_W'(N_SAMPLES - 1);

    state_e                   state;
    logic [CLS_W-1:0]         cls_cnt;
    logic [CLS_W-1:0]         arg_r;
    logic signed [DATA_W-1:0] max_r;
    logic [CNT_W-1:0]         smp_cnt;

    logic                     beat;
    logic                     first;
    logic                     at_end;
    logic                     take;
    logic                     emit;
    logic                     early;
    logic                     late;
    logic signed [DATA_W-1:0] din;
    logic signed [DATA_W-1:0] nxt_max;
    logic [CLS_W-1:0]         nxt_arg;

    // Running max including the current beat; ties keep the lower index.
    always_comb begin
        din     = $signed(bus.in_data);
        beat    = bus.in_valid && (state == RUN);
        first   = (cls_cnt == '0);
        at_end  = (cls_cnt == CLS_LAST);
        take    = first || (din > max_r);
        nxt_max = take ? din : max_r;
        nxt_arg = first ? '0 : (take ? cls_cnt : arg_r);
        emit    = beat && at_end;
        early   = beat && bus.in_last && !at_end;
        late    = beat && !bus.in_last && at_end;
    end

    // Control FSM: class position, running max, sample count, framing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RUN;
            cls_cnt <= '0;
            arg_r   <= '0;
            max_r   <= '0;
            smp_cnt <= '0;
            bus.err <= 1'b0;
        end else begin
            if (beat) begin
                max_r   <= nxt_max;
                arg_r   <= nxt_arg;
                cls_cnt <= (at_end || early) ? '0 : cls_cnt + 1'b1;
            end
            if (emit) begin
                smp_cnt <= smp_cnt + 1'b1;
                if (smp_cnt == SMP_LAST) begin
                    state <= FINISH;
                end
            end
            if (early || late) begin
                bus.err <= 1'b1;
            end
        end
    end

    // Registered result; fields only move with an out_valid pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid  <= 1'b0;
            bus.out_class  <= '0;
            bus.out_score  <= '0;
            bus.sample_idx <= '0;
            bus.done       <= 1'b0;
        end else begin
            bus.out_valid <= emit;
            if (emit) begin
                bus.out_class  <= nxt_arg;
                bus.out_score  <= nxt_max;
                bus.sample_idx <= smp_cnt;
                if (smp_cnt == SMP_LAST) begin
                    bus.done <= 1'b1;
                end
            end
        end
    end

endmodule
